// File: rtl/instr_encode_loader_if.sv
// Decoded-field tuple channel (valid/ready) feeding the RV32I encoder/loader.
interface instr_encode_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  // Producer of field tuples
  modport master (
    output in_valid, in_opcode, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  // Consumer of field tuples (the loader)
  modport slave (
    input  in_valid, in_opcode, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_encode_loader.sv
// RV32I instruction encoder and IMEM program loader.
// Packs decoded fields into 32-bit words and writes them to sequential IMEM
// word addresses starting at BASE_ADDR, wrapping modulo 2**ADDR_W.
// Optional feature macro: IMEM_PAD_EN (pads the rest of IMEM with NOPs after finish).
module instr_encode_loader #(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       finish,
  instr_encode_loader_if.slave       in_bus,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [ADDR_W:0]            count
);

  localparam int unsigned     CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]     NOP   = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_OP   = 2'b01;
  localparam logic [1:0] E_IMM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef IMEM_PAD_EN
    PAD  = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic [1:0]        enc_err;
  logic              accept;
  logic              word_fire;
  logic [CNT_W-1:0]  count_n;
  logic [31:0]       imm;

  assign imm = in_bus.in_imm;

  // Space check: count already includes the word being written this cycle.
  assign in_bus.in_ready = (state == LOAD) && (count < DEPTH);
  assign accept          = in_bus.in_valid && in_bus.in_ready;

  // Field packing and immediate range/alignment check
  always_comb begin
    enc_word = '0;
    enc_err  = E_NONE;
    case (in_bus.in_opcode)
      OP_R: begin
        enc_word = {in_bus.in_func7, in_bus.in_rs2, in_bus.in_rs1, in_bus.in_func3,
                    in_bus.in_rd, in_bus.in_opcode};
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word = {imm[11:0], in_bus.in_rs1, in_bus.in_func3, in_bus.in_rd, in_bus.in_opcode};
        if (!((&imm[31:11]) || !(|imm[31:11]))) enc_err = E_IMM;
      end
      OP_STORE: begin
        enc_word = {imm[11:5], in_bus.in_rs2, in_bus.in_rs1, in_bus.in_func3, imm[4:0],
                    in_bus.in_opcode};
        if (!((&imm[31:11]) || !(|imm[31:11]))) enc_err = E_IMM;
      end
      OP_BR: begin
        enc_word = {imm[12], imm[10:5], in_bus.in_rs2, in_bus.in_rs1, in_bus.in_func3,
                    imm[4:1], imm[11], in_bus.in_opcode};
        if (!((&imm[31:12]) || !(|imm[31:12])) || imm[0]) enc_err = E_IMM;
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], in_bus.in_rd, in_bus.in_opcode};
        if (!((&imm[31:20]) || !(|imm[31:20])) || imm[0]) enc_err = E_IMM;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], in_bus.in_rd, in_bus.in_opcode};
        if (|imm[11:0]) enc_err = E_IMM;
      end
      default: enc_err = E_OP;
    endcase
  end

  // A word goes out on a clean accepted tuple, or every cycle while padding
  always_comb begin
    word_fire = 1'b0;
    if (state == LOAD) word_fire = accept && (enc_err == E_NONE);
`ifdef IMEM_PAD_EN
    else if (state == PAD) word_fire = 1'b1;
`endif
  end

  assign count_n = count + {{ADDR_W{1'b0}}, word_fire};

  // Loader FSM with registered write port and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= E_NONE;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;

      if (word_fire) begin
        imem_we    <= 1'b1;
        imem_addr  <= wr_ptr;
        imem_wdata <= enc_word;
`ifdef IMEM_PAD_EN
        if (state == PAD) imem_wdata <= NOP;
`endif
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        count      <= count_n;
      end

      // Only the first rejection is recorded until the next start
      if (accept && (enc_err != E_NONE) && !err) begin
        err      <= 1'b1;
        err_code <= enc_err;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            count    <= '0;
            wr_ptr   <= BASE_ADDR;
            err      <= 1'b0;
            err_code <= E_NONE;
          end
        end
        LOAD: begin
          if (finish || (count_n == DEPTH)) begin
`ifdef IMEM_PAD_EN
            if (count_n != DEPTH) begin
              state <= PAD;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
`ifdef IMEM_PAD_EN
        PAD: begin
          if (count_n == DEPTH) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader (ADDR_W=2, BASE_ADDR=2 so the
// address wrap is exercised); directed steps followed by random tuples.
module tb_instr_encode_loader;

  localparam int unsigned AW    = 2;
  localparam logic [AW-1:0] BASE = 2'd2;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          finish;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_ptr;
  int            exp_count;
  logic          exp_err;
  logic [1:0]    exp_code;

  instr_encode_loader_if bus ();

  instr_encode_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_bus     (bus.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder written from the format table and numeric ranges
  function automatic void model_enc(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm, output logic ok,
                                    output logic [31:0] w, output logic [1:0] code);
    int v;
    v = $signed(imm);
    ok = 1'b1;
    w = '0;
    case (op)
      7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w = {imm[11:0], rs1, f3, rd, op};
        ok = (v >= -2048) && (v <= 2047);
      end
      7'b0100011: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        ok = (v >= -2048) && (v <= 2047);
      end
      7'b1100011: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      end
      7'b1101111: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      end
      7'b0110111, 7'b0010111: begin
        w = {imm[31:12], rd, op};
        ok = (imm % 32'd4096) == 0;
      end
      default: ok = 1'b0;
    endcase
    if (ok) code = 2'b00;
    else if (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                        7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111}) code = 2'b10;
    else code = 2'b01;
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_ptr   = BASE;
    exp_count = 0;
    exp_err   = 1'b0;
    exp_code  = 2'b00;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(count), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_err_code", 32'(err_code), 32'd0);
  endtask

  // Offer one tuple (optionally with finish) and check the cycle after acceptance
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic fin);
    logic ok;
    logic [31:0] w;
    logic [1:0] code;
    model_enc(op, f3, f7, rd, rs1, rs2, imm, ok, w, code);
    chk("send_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready !== 1'b1) return;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_func3  = f3;
    bus.in_func7  = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    finish        = fin;
    step();
    bus.in_valid = 1'b0;
    finish       = 1'b0;
    if (ok) begin
      chk("wr_we", 32'(imem_we), 32'd1);
      chk("wr_addr", 32'(imem_addr), 32'(exp_ptr));
      chk("wr_data", imem_wdata, w);
      exp_ptr = exp_ptr + 2'd1;
      exp_count++;
    end else begin
      chk("rej_we", 32'(imem_we), 32'd0);
      if (!exp_err) begin
        exp_err  = 1'b1;
        exp_code = code;
      end
    end
    chk("count", 32'(count), 32'(exp_count));
    chk("err", 32'(err), 32'(exp_err));
    chk("err_code", 32'(err_code), 32'(exp_code));
  endtask

  task automatic finish_pulse();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("fin_we", 32'(imem_we), 32'd0);
  endtask

  // After the FSM leaves LOAD: NOP padding (if built in), then DONE
  task automatic finish_tail();
`ifdef IMEM_PAD_EN
    while (exp_count < DEPTH) begin
      step();
      chk("pad_we", 32'(imem_we), 32'd1);
      chk("pad_addr", 32'(imem_addr), 32'(exp_ptr));
      chk("pad_data", imem_wdata, 32'h0000_0013);
      exp_ptr = exp_ptr + 2'd1;
      exp_count++;
      chk("pad_count", 32'(count), 32'(exp_count));
    end
`endif
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("done_idle_we", 32'(imem_we), 32'd0);
    chk("done_count", 32'(count), 32'(exp_count));
  endtask

  initial begin
    logic [6:0]  ops [10];
    logic [6:0]  op;
    logic [31:0] imm;
    logic [20:0] t21;
    logic        fin;
    logic        ended;

    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};

    rst_n = 1'b0;
    start = 1'b0;
    finish = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_func3 = '0;
    bus.in_func7 = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(BASE));
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);

    // Load 1: ADDI, ignored start, SW, BEQ (address wraps), finish
    do_start();
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    chk("addi_word", imem_wdata, 32'h0050_0093);
    chk("addi_addr", 32'(imem_addr), 32'(BASE));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_count", 32'(count), 32'd1);
    chk("start_ignored_busy", 32'(busy), 32'd1);
    send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    chk("sw_word", imem_wdata, 32'h0020_A423);
    send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0);
    chk("beq_word", imem_wdata, 32'hFE00_0EE3);
    chk("beq_addr_wrap", 32'(imem_addr), 32'd0);
    finish_pulse();
    finish_tail();

    // Load 2: LUI good/bad, then a tuple accepted together with finish
    do_start();
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    chk("lui_word", imem_wdata, 32'h1234_52B7);
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0);
    chk("lui_bad_code", 32'(err_code), 32'd2);
    send(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, -32'sd2048, 1'b1);
    finish_tail();

    // Load 3: illegal opcode then misaligned branch; first error is held
    do_start();
    send(7'b1111111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
    chk("first_err_held", 32'(err_code), 32'd1);
    finish_pulse();
    finish_tail();
    do_start();

    // Load 4: capacity limit at DEPTH words
    for (int i = 0; i < DEPTH; i++)
      send(7'b0010011, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3), 1'b0);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("full_no_we", 32'(imem_we), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    finish_tail();

    // Random loads against the reference model
    for (int ld = 0; ld < 12; ld++) begin
      do_start();
      ended = 1'b0;
      for (int i = 0; i < 6 && !ended; i++) begin
        op = ops[$urandom_range(0, 9)];
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
          2: imm = $urandom & 32'hFFFF_F000;
          default: begin
            t21 = 21'($urandom);
            imm = {{11{t21[20]}}, t21[20:1], 1'b0};
          end
        endcase
        fin = ($urandom_range(0, 4) == 0);
        send(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             imm, fin);
        if (fin || exp_count == DEPTH) ended = 1'b1;
      end
      if (!ended) finish_pulse();
      finish_tail();
    end

    // Reset mid-LOAD with a write pending
    do_start();
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
    send(7'b0000000, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_opcode = 7'b0010011;
    bus.in_imm    = 32'd9;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_code", 32'(err_code), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'(BASE));
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
